rgb_pwm_driver: RTL and testbench
=================================

RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

Interface
REQ-001 Parameter PRESCALE, default 1000, clk cycles per PWM slot tick; legal range 2..65535.
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 level  input  5  brightness from the rotary encoder stage; valid 0..15, values 16..31 SHALL be clamped to 15.
REQ-005 sel_btn  input  1  asynchronous raw push button, active-high; each press advances the active colour channel.
REQ-006 sel  output  2  active channel: 0=R, 1=G, 2=B; 3 never driven.
REQ-007 led_r  output  1  red PWM drive, active-high, registered.
REQ-008 led_g  output  1  green PWM drive, active-high, registered.
REQ-009 led_b  output  1  blue PWM drive, active-high, registered.

Function
REQ-010 sel_btn SHALL pass through a 2-flop synchroniser; a rising edge on the synchronised signal SHALL yield a one-cycle advance pulse.
REQ-011 Advance pulse SHALL step sel R->G->B->R, effective the next cycle; holding the button SHALL produce exactly one step.
REQ-012 Each channel SHALL have a 4-bit shadow duty register; only the shadow of the channel selected by sel SHALL load clamp(level) every cycle; the others SHALL hold.
REQ-013 If an advance pulse and a level change coincide, the shadow load in that cycle SHALL target the old sel value.
REQ-014 Prescaler: counter 0..PRESCALE-1, wrapping to 0; tick SHALL be asserted for one cycle when it equals PRESCALE-1.
REQ-015 Slot counter: 4-bit, SHALL increment on tick, wrapping 15->0; one PWM period = 16 ticks = 16*PRESCALE cycles.
REQ-016 Each channel SHALL have a 4-bit active duty register that loads its shadow only on tick while the slot counter = 15, i.e. at the period boundary; no mid-period duty change.
REQ-017 led_x SHALL be registered as (slot counter < active duty_x), giving a one-cycle latency from the slot counter.
REQ-018 Duty 0 SHALL keep the LED constantly low; duty N SHALL give N high slots per 16, contiguous from slot 0; duty 15 gives 15/16.
REQ-019 The clamp SHALL be combinational on level (level[4]=1 -> 4'hF, else level[3:0]); no arithmetic wraps.
REQ-020 With all active duties 0, all three LEDs SHALL remain low indefinitely.

Reset
REQ-021 With rst=1 on a clock edge: sel=0, all shadow and active duties=0, prescaler=0, slot counter=0, synchroniser and edge flops=0, led_r/g/b=0.
REQ-022 rst SHALL override all other activity, including a pending advance pulse and period-boundary loads.
REQ-023 After rst deasserts, prescaler counting SHALL begin on the first following edge; the first period boundary SHALL occur 16*PRESCALE cycles later.
REQ-024 A button held high through reset deassertion SHALL NOT generate an advance (synchroniser restarts at 0 but the bench requires the edge to be seen only from a low level; hold detect is the edge flop).
REQ-025 Reset asserted mid-period SHALL force the LEDs low on the next cycle; no partial pulse SHALL follow.

Verification (bench PRESCALE=2, period 32 cycles)
REQ-026 Reset, level=8 held, sel=R -> after the first boundary led_r high 16 cycles / low 16 cycles per period; led_g=led_b=0.
REQ-027 level=20 -> red duty clamps to 15: led_r high 30 of every 32 cycles.
REQ-028 One button press (10 cycles high), then level=4 -> sel=1 within 4 cycles; led_g 8/32 high; led_r keeps its previous duty.
REQ-029 level changed 0->12 mid-period -> current period keeps the old duty; the new duty appears only from the next slot-0.
REQ-030 Three presses -> sel returns to 0; a single 200-cycle press advances sel exactly once.
REQ-031 rst pulsed mid-period with led_r high -> next cycle all LEDs=0, sel=0; subsequent periods all LEDs low until level is reloaded.

Source files
------------

// File: rtl/rgb_pwm_driver.sv
// Three-channel 16-level PWM LED driver with a push-button channel selector.
// Duty updates are staged in shadows and only applied at the PWM period boundary.
module rgb_pwm_driver #(
  parameter int PRESCALE = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] level,
  input  logic       sel_btn,
  output logic [1:0] sel,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
  localparam logic [1:0]  SEL_R   = 2'd0;
  localparam logic [1:0]  SEL_B   = 2'd2;
  localparam logic [1:0]  WARM_DONE = 2'd2;

  logic       btn_meta_q, btn_sync_q, btn_prev_q;
  logic [1:0] warm_q, warm_d;
  logic       armed_q, armed_d;
  logic       adv;

  logic [1:0]  sel_q, sel_d;
  logic [15:0] pre_q, pre_d;
  logic [3:0]  slot_q, slot_d;
  logic        tick;
  logic        boundary;
  logic [3:0]  level_clamped;
  logic [2:0]  led_vec;

  // Edge detection is only armed once the synchroniser has seen the button low
  // after reset, so a button held through reset never produces a step.
  always_comb begin
    warm_d  = (warm_q == WARM_DONE) ? warm_q : warm_q + 2'd1;
    armed_d = armed_q | ((warm_q == WARM_DONE) & ~btn_sync_q);
  end

  assign adv = armed_q & btn_sync_q & ~btn_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_prev_q <= 1'b0;
      warm_q     <= 2'd0;
      armed_q    <= 1'b0;
    end else begin
      btn_meta_q <= sel_btn;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
      warm_q     <= warm_d;
      armed_q    <= armed_d;
    end
  end

  always_comb begin
    sel_d = sel_q;
    if (adv) begin
      sel_d = (sel_q == SEL_B) ? SEL_R : sel_q + 2'd1;
    end
  end

  assign tick     = (pre_q == PRE_MAX);
  assign boundary = tick & (slot_q == 4'hF);

  always_comb begin
    pre_d  = tick ? 16'd0 : pre_q + 16'd1;
    slot_d = tick ? slot_q + 4'd1 : slot_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= SEL_R;
      pre_q  <= 16'd0;
      slot_q <= 4'd0;
    end else begin
      sel_q  <= sel_d;
      pre_q  <= pre_d;
      slot_q <= slot_d;
    end
  end

  assign level_clamped = level[4] ? 4'hF : level[3:0];

  // Shadow loads use the current sel, so a coincident advance still writes the old channel.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] active_q, active_d;
    logic       led_q, led_d;

    always_comb begin
      shadow_d = (sel_q == 2'(gi)) ? level_clamped : shadow_q;
      active_d = boundary ? shadow_q : active_q;
      led_d    = (slot_q < active_q);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_q <= 4'd0;
        active_q <= 4'd0;
        led_q    <= 1'b0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
        led_q    <= led_d;
      end
    end

    assign led_vec[gi] = led_q;
  end

  assign sel   = sel_q;
  assign led_r = led_vec[0];
  assign led_g = led_vec[1];
  assign led_b = led_vec[2];

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver at PRESCALE=2 (32-cycle PWM period).
module tb_rgb_pwm_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] level;
  logic       sel_btn;
  logic [1:0] sel;
  logic       led_r, led_g, led_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_r, cnt_g, cnt_b;

  rgb_pwm_driver #(.PRESCALE(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .level   (level),
    .sel_btn (sel_btn),
    .sel     (sel),
    .led_r   (led_r),
    .led_g   (led_g),
    .led_b   (led_b)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic count_window(input int n);
    cnt_r = 0; cnt_g = 0; cnt_b = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cnt_r += int'(led_r);
      cnt_g += int'(led_g);
      cnt_b += int'(led_b);
    end
  endtask

  task automatic press(input int n);
    sel_btn = 1'b1;
    step(n);
    sel_btn = 1'b0;
    step(6);
  endtask

  task automatic test_reset;
    int k;
    rst = 1'b1; level = 5'd8; sel_btn = 1'b0;
    step(3);
    n_cmp++;
    if (sel !== 2'd0 || {led_r, led_g, led_b} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_state: sel=%0d leds=%b required sel=0 leds=000", sel, {led_r, led_g, led_b});
    end
    rst = 1'b0;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (led_r === 1'b1) begin
        k = i;
        break;
      end
    end
    n_cmp++;
    if (k != 33) begin
      n_bad++;
      $display("FAIL first_boundary: led_r rose after %0d cycles required 33", k);
    end
    $display("reset: first led_r rise after %0d cycles", k);
  endtask

  task automatic test_half_duty;
    count_window(32);
    n_cmp++;
    if (cnt_r != 16 || cnt_g != 0 || cnt_b != 0) begin
      n_bad++;
      $display("FAIL duty8: r/g/b high=%0d/%0d/%0d required 16/0/0", cnt_r, cnt_g, cnt_b);
    end
    $display("duty8: r/g/b high=%0d/%0d/%0d", cnt_r, cnt_g, cnt_b);
  endtask

  task automatic test_clamp;
    level = 5'd20;
    step(70);
    count_window(32);
    n_cmp++;
    if (cnt_r != 30 || cnt_g != 0 || cnt_b != 0) begin
      n_bad++;
      $display("FAIL clamp: r/g/b high=%0d/%0d/%0d required 30/0/0", cnt_r, cnt_g, cnt_b);
    end
    $display("clamp: r/g/b high=%0d/%0d/%0d", cnt_r, cnt_g, cnt_b);
  endtask

  task automatic test_advance;
    int k;
    sel_btn = 1'b1;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (k == 0 && sel === 2'd1) k = i;
    end
    sel_btn = 1'b0;
    n_cmp++;
    if (k < 1 || k > 4) begin
      n_bad++;
      $display("FAIL advance_latency: sel=1 after %0d cycles required 1..4", k);
    end
    step(6);
    n_cmp++;
    if (sel !== 2'd1) begin
      n_bad++;
      $display("FAIL advance_once: sel=%0d required 1", sel);
    end
    level = 5'd4;
    step(70);
    count_window(32);
    n_cmp++;
    if (cnt_r != 30 || cnt_g != 8 || cnt_b != 0) begin
      n_bad++;
      $display("FAIL green4: r/g/b high=%0d/%0d/%0d required 30/8/0", cnt_r, cnt_g, cnt_b);
    end
    $display("advance: latency=%0d sel=%0d r/g/b high=%0d/%0d/%0d", k, sel, cnt_r, cnt_g, cnt_b);
  endtask

  task automatic test_mid_period;
    bit found;
    press(10);
    n_cmp++;
    if (sel !== 2'd2) begin
      n_bad++;
      $display("FAIL sel_blue: sel=%0d required 2", sel);
    end
    level = 5'd0;
    step(70);
    // Align to slot 0 using the green channel's rising edge.
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (led_g === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      found = 1'b0;
      for (int i = 0; i < 64; i++) begin
        step(1);
        if (led_g === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL align_timeout: led_g rise not seen within 128 cycles");
    end
    count_window(8);
    cnt_b = cnt_b;
    level = 5'd12;
    begin
      int b0;
      b0 = cnt_b;
      count_window(23);
      n_cmp++;
      if (b0 + cnt_b != 0) begin
        n_bad++;
        $display("FAIL no_mid_change: led_b high=%0d in current period required 0", b0 + cnt_b);
      end
    end
    count_window(32);
    n_cmp++;
    if (cnt_b != 24 || cnt_g != 8) begin
      n_bad++;
      $display("FAIL blue12: g/b high=%0d/%0d required 8/24", cnt_g, cnt_b);
    end
    $display("mid_period: next period g/b high=%0d/%0d", cnt_g, cnt_b);
  endtask

  task automatic test_wrap_and_hold;
    int changes;
    logic [1:0] prev_sel;
    press(10);
    n_cmp++;
    if (sel !== 2'd0) begin
      n_bad++;
      $display("FAIL wrap: sel=%0d required 0", sel);
    end
    changes = 0;
    prev_sel = sel;
    sel_btn = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (sel !== prev_sel) changes++;
      prev_sel = sel;
    end
    sel_btn = 1'b0;
    step(10);
    n_cmp++;
    if (changes != 1 || sel !== 2'd1) begin
      n_bad++;
      $display("FAIL long_press: changes=%0d sel=%0d required 1/1", changes, sel);
    end
    $display("long_press: changes=%0d sel=%0d", changes, sel);
  endtask

  task automatic test_reset_mid;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (led_r === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL led_r_timeout: led_r never high before mid-period reset");
    end
    rst = 1'b1;
    level = 5'd0;
    step(1);
    rst = 1'b0;
    n_cmp++;
    if (sel !== 2'd0 || {led_r, led_g, led_b} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_mid: sel=%0d leds=%b required sel=0 leds=000", sel, {led_r, led_g, led_b});
    end
    count_window(96);
    n_cmp++;
    if (cnt_r + cnt_g + cnt_b != 0) begin
      n_bad++;
      $display("FAIL dark_after_reset: r/g/b high=%0d/%0d/%0d required 0/0/0", cnt_r, cnt_g, cnt_b);
    end
    $display("reset_mid: r/g/b high over 96 cycles=%0d/%0d/%0d", cnt_r, cnt_g, cnt_b);
  endtask

  task automatic test_held_through_reset;
    sel_btn = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(20);
    sel_btn = 1'b0;
    step(6);
    n_cmp++;
    if (sel !== 2'd0) begin
      n_bad++;
      $display("FAIL held_reset: sel=%0d required 0", sel);
    end
    press(10);
    n_cmp++;
    if (sel !== 2'd1) begin
      n_bad++;
      $display("FAIL press_after_held: sel=%0d required 1", sel);
    end
    $display("held_through_reset: sel after fresh press=%0d", sel);
  endtask

  initial begin
    rst = 1'b1; level = 5'd0; sel_btn = 1'b0;
    test_reset;
    test_half_duty;
    test_clamp;
    test_advance;
    test_mid_period;
    test_wrap_and_hold;
    test_reset_mid;
    test_held_through_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
